mul163_d8_ctrl: RTL and testbench

//  Sequencer for the GF(2^163) digit-serial systolic multiplier (8-bit digits).

---
 rtl/mul163_d8_ctrl.sv | 150 +++++++++++++++
 tb/tb_mul163_d8_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul163_d8_ctrl.sv
// Sequencer for the GF(2^163) digit-serial systolic multiplier with 8-bit digits.
// It clears the array, feeds operand B one digit per cycle (MSB digit first), waits for the drain, and captures the product.
module mul163_d8_ctrl #(
    parameter int M         = 163,
    parameter int D         = 8,
    parameter int NDIG      = (M + D - 1) / D,
    parameter int DRAIN_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [M-1:0] op_a,
    input  logic [M-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result,
    output logic         arr_clr,
    output logic         arr_en,
    output logic [M-1:0] arr_a,
    output logic [D-1:0] arr_digit,
    input  logic [M-1:0] arr_res
);

    localparam int CNT_MAX = (NDIG > DRAIN_LAT) ? NDIG : DRAIN_LAT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic            w_accept;
    logic            w_capture;

    logic [M-1:0]    r_a;
    logic [M-1:0]    r_b;
    logic [M-1:0]    r_result;
    logic            r_busy;
    logic            r_done;
    logic            r_clr;
    logic            r_en;
    logic [D-1:0]    r_digit;

    // B is zero-padded at the top so the MSB digit carries only the leftover bits.
    logic [NDIG*D-1:0] w_b_pad;
    logic [D-1:0]      w_digits [NDIG];

    assign w_b_pad = {{(NDIG*D-M){1'b0}}, r_b};

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        assign w_digits[g] = w_b_pad[g*D +: D];
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FEED;
                    w_next_cnt   = CW'(NDIG - 1);
                end
            end
            S_FEED: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = S_DRAIN;
                    w_next_cnt   = CW'(DRAIN_LAT - 1);
                end else begin
                    w_next_cnt   = r_cnt - CW'(1);
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt   = r_cnt - CW'(1);
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing on an input reaches an output combinationally.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_clr    <= 1'b0;
            r_en     <= 1'b0;
            r_digit  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_a <= op_a;
                r_b <= op_b;
            end
            if (w_capture) begin
                r_result <= arr_res;
            end
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (w_next_state == S_DONE);
            r_clr   <= (w_next_state == S_CLEAR);
            r_en    <= (w_next_state == S_FEED);
            r_digit <= (w_next_state == S_FEED) ? w_digits[w_next_cnt] : '0;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign arr_clr   = r_clr;
    assign arr_en    = r_en;
    assign arr_a     = r_a;
    assign arr_digit = r_digit;

endmodule

// File: tb/tb_mul163_d8_ctrl.sv
// Self-checking bench for mul163_d8_ctrl: a behavioural GF(2^163) array drives arr_res.
// A phase-since-accept timing model predicts every output on every cycle.
module tb_mul163_d8_ctrl;

    localparam int M           = 163;
    localparam int D           = 8;
    localparam int NDIG        = 21;
    localparam int DRAIN_LAT   = 2;
    localparam int P_FEED0     = 2;
    localparam int P_FEED1     = NDIG + 1;
    localparam int P_LASTDRAIN = NDIG + 1 + DRAIN_LAT;
    localparam int P_DONE      = NDIG + 2 + DRAIN_LAT;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [M-1:0] op_a;
    logic [M-1:0] op_b;
    logic         busy;
    logic         done;
    logic [M-1:0] result;
    logic         arr_clr;
    logic         arr_en;
    logic [M-1:0] arr_a;
    logic [D-1:0] arr_digit;
    logic [M-1:0] arr_res;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    int           phase = 0;
    logic [M-1:0] ea    = '0;
    logic [M-1:0] eb    = '0;
    logic [M-1:0] eres  = '0;

    always #5 clk = ~clk;

    mul163_d8_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .arr_clr   (arr_clr),
        .arr_en    (arr_en),
        .arr_a     (arr_a),
        .arr_digit (arr_digit),
        .arr_res   (arr_res)
    );

    // Multiplication in GF(2^163) modulo x^163 + x^7 + x^6 + x^3 + 1.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] aa;
        logic         msb;
        r  = '0;
        aa = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ aa;
            msb = aa[M-1];
            aa  = aa << 1;
            if (msb) aa = aa ^ 163'hC9;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rand163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    // Behavioural multiplier array: acc = acc*x^8 + a*digit, one extra register stage on the output.
    logic [M-1:0] acc   = '0;
    logic [M-1:0] res_q = '0;
    always @(posedge clk) begin
        if (arr_clr)     acc <= '0;
        else if (arr_en) acc <= gf_mul(acc, 163'h100) ^ gf_mul(arr_a, M'(arr_digit));
        res_q <= acc;
    end
    assign arr_res = res_q;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NDIG*D-1:0] bp;
        logic [D-1:0]      exp_digit;
        int                k;
        bp        = {{(NDIG*D-M){1'b0}}, eb};
        exp_digit = '0;
        if (phase >= P_FEED0 && phase <= P_FEED1) begin
            k         = NDIG - 1 - (phase - P_FEED0);
            exp_digit = bp[k*D +: D];
        end
        check("busy",      M'(busy),      M'(phase != 0));
        check("done",      M'(done),      M'(phase == P_DONE));
        check("arr_clr",   M'(arr_clr),   M'(phase == 1));
        check("arr_en",    M'(arr_en),    M'(phase >= P_FEED0 && phase <= P_FEED1));
        check("arr_digit", M'(arr_digit), M'(exp_digit));
        check("arr_a",     arr_a,         ea);
        check("result",    result,        eres);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it.
    task automatic step(input logic s, input logic ab, input logic r,
                        input logic [M-1:0] a, input logic [M-1:0] b);
        start = s;
        abort = ab;
        rst   = r;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        if (r) begin
            phase = 0;
            ea    = '0;
            eres  = '0;
        end else if (phase == 0) begin
            if (s && !ab) begin
                phase = 1;
                ea    = a;
                eb    = b;
            end
        end else if (ab && phase < P_DONE) begin
            phase = 0;
        end else if (phase == P_DONE) begin
            phase = 0;
        end else begin
            if (phase == P_LASTDRAIN) eres = gf_mul(ea, eb);
            phase++;
        end
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, rand163(), rand163());
    endtask

    initial begin
        logic [M-1:0]      a1, b1, a2, b2, a3, b3, a4, b4;
        logic [NDIG*D-1:0] pat;

        // Reset held 3 cycles with start high; start must be ignored.
        repeat (3) step(1'b1, 1'b0, 1'b1, rand163(), rand163());
        run_idle(2);

        // a = 1, b = 1
        step(1'b1, 1'b0, 1'b0, 163'h1, 163'h1);
        run_idle(26);
        check("t2_result", result, 163'h1);

        // x^162 * x = x^163, reduced
        step(1'b1, 1'b0, 1'b0, 163'h1 << 162, 163'h2);
        run_idle(26);
        check("t3_result", result, 163'hC9);

        // Digit k = k+1, top digit 3'b111
        pat = '0;
        for (int k = 0; k < NDIG - 1; k++) pat[k*D +: D] = 8'(k + 1);
        pat[(NDIG-1)*D +: D] = 8'h07;
        step(1'b1, 1'b0, 1'b0, rand163(), pat[M-1:0]);
        run_idle(26);

        // start re-asserted while busy is ignored; next start accepted in IDLE
        a1 = rand163(); b1 = rand163(); a2 = rand163(); b2 = rand163();
        step(1'b1, 1'b0, 1'b0, a1, b1);
        for (int c = 1; c <= 25; c++) step((c == 5 || c == 25), 1'b0, 1'b0, a2, b2);
        check("t5_result", result, gf_mul(a1, b1));
        step(1'b1, 1'b0, 1'b0, a2, b2);
        run_idle(26);
        check("t5_second", result, gf_mul(a2, b2));

        // abort in cycle 10, new start in cycle 12
        a3 = rand163(); b3 = rand163(); a4 = rand163(); b4 = rand163();
        step(1'b1, 1'b0, 1'b0, a3, b3);
        for (int c = 1; c <= 11; c++) step(1'b0, (c == 10), 1'b0, rand163(), rand163());
        check("t6_kept", result, gf_mul(a2, b2));
        step(1'b1, 1'b0, 1'b0, a4, b4);
        run_idle(26);
        check("t6_second", result, gf_mul(a4, b4));

        // rst in cycle 10 drops the operation and clears the result
        step(1'b1, 1'b0, 1'b0, a3, b3);
        for (int c = 1; c <= 9; c++) step(1'b0, 1'b0, 1'b0, rand163(), rand163());
        step(1'b0, 1'b0, 1'b1, rand163(), rand163());
        run_idle(20);
        check("t6_rst_result", result, '0);

        // Randomized traffic with start noise, aborts and occasional resets
        for (int op = 0; op < 40; op++) begin
            logic s;
            logic ab;
            logic r;
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, rand163(), rand163());
            if ($urandom_range(0, 4) == 0) step(1'b1, 1'b1, 1'b0, rand163(), rand163());
            step(1'b1, 1'b0, 1'b0, rand163(), rand163());
            for (int c = 0; c < 26; c++) begin
                s  = ($urandom_range(0, 7) == 0);
                ab = ($urandom_range(0, 59) == 0);
                r  = ($urandom_range(0, 299) == 0);
                step(s, ab, r, rand163(), rand163());
            end
        end
        run_idle(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
